// File: rtl/alaw_decode_arbiter_if.sv
// alaw_decode_arbiter_if
//   Bundles the per-channel A-law sample inputs and the decoded-sample
//   output stream of alaw_decode_arbiter.
//   Parameters: NUM_CH (number of channels), CHW (channel index width).
//   Signals:
//     in_valid  [NUM_CH]    per-channel sample valid (source -> arbiter)
//     in_ready  [NUM_CH]    per-channel accept, one-hot or zero (arbiter -> source)
//     in_alaw   [8*NUM_CH]  channel i code at [8*i+7:8*i]
//     out_valid             decoded sample valid (arbiter -> sink)
//     out_ready             sink accept (sink -> arbiter)
//     out_lin   [13]        {sign, 12-bit magnitude}
//     out_ch    [CHW]       source channel of out_lin
//   Modports: master = sources/sink side, slave = arbiter side.
interface alaw_decode_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CHW    = 2
);
    logic [NUM_CH-1:0]   in_valid;
    logic [NUM_CH-1:0]   in_ready;
    logic [8*NUM_CH-1:0] in_alaw;
    logic                out_valid;
    logic                out_ready;
    logic [12:0]         out_lin;
    logic [CHW-1:0]      out_ch;

    modport master (
        output in_valid, in_alaw, out_ready,
        input  in_ready, out_valid, out_lin, out_ch
    );

    modport slave (
        input  in_valid, in_alaw, out_ready,
        output in_ready, out_valid, out_lin, out_ch
    );
endinterface

// File: rtl/alaw_decode_arbiter.sv
// alaw_decode_arbiter
//   Shares one combinational A-law expander between NUM_CH sample sources.
//   Round-robin arbitration with optional bursts of up to BURST samples per
//   grant; one registered valid/ready output stream tags every decoded
//   sample with its source channel (latency 1, one sample per cycle).
//   Optional feature macro: ALAW_ARB_STATS_EN adds saturating per-channel
//   accept counters (CNT_W wide) readable through cnt_sel/cnt_val.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous reset, active high
//     cnt_sel  counter select            (ALAW_ARB_STATS_EN only)
//     cnt_val  selected counter value    (ALAW_ARB_STATS_EN only)
//     bus      alaw_decode_arbiter_if.slave (inputs, readies, decoded output)
module alaw_decode_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CHW    = 2,
    parameter int BURST  = 1
`ifdef ALAW_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ALAW_ARB_STATS_EN
    input  logic [CHW-1:0]       cnt_sel,
    output logic [CNT_W-1:0]     cnt_val,
`endif
    alaw_decode_arbiter_if.slave bus
);

    typedef enum logic {ARB, HOLD} state_t;

    state_t            state;
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    lock;
    logic [3:0]        burst_cnt;
    logic [CHW-1:0]    grant;
    logic              grant_found;
    logic [CHW-1:0]    sel_ch;
    logic [7:0]        sel_code;
    logic [NUM_CH-1:0] ready_vec;
    logic              slot_free;
    logic              xfer;
    logic              burst_done;

    // A-law expansion to {sign, 12-bit magnitude}. Segment 0 is linear
    // (2*mant+1); higher segments add the implicit leading one and shift.
    function automatic logic [12:0] expand(input logic [7:0] code);
        logic [2:0]  seg;
        logic [3:0]  mant;
        logic [11:0] mag;
        seg  = code[6:4];
        mant = code[3:0];
        if (seg == 3'd0) begin
            mag = {7'd0, mant, 1'b1};
        end else begin
            mag = {6'd0, 1'b1, mant, 1'b1} << (seg - 3'd1);
        end
        return {code[7], mag};
    endfunction

    function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ch);
        if (ch == CHW'(NUM_CH - 1)) begin
            return '0;
        end
        return ch + CHW'(1);
    endfunction

    assign slot_free  = ~bus.out_valid | bus.out_ready;
    assign burst_done = (burst_cnt + 4'd1) == 4'(BURST);

    // Round-robin search starting at rr_ptr; first valid channel wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_found && bus.in_valid[CHW'((int'(rr_ptr) + k) % NUM_CH)]) begin
                grant       = CHW'((int'(rr_ptr) + k) % NUM_CH);
                grant_found = 1'b1;
            end
        end
    end

    // In HOLD the locked channel keeps its ready regardless of its own
    // valid, so in_ready never waits on the channel it is offered to.
    // Ready is also suppressed while reset is asserted.
    always_comb begin
        ready_vec = '0;
        sel_ch    = (state == HOLD) ? lock : grant;
        if (!rst && (state == HOLD || grant_found)) begin
            ready_vec[sel_ch] = slot_free;
        end
    end

    always_comb begin
        sel_code = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CHW'(k) == sel_ch) begin
                sel_code = bus.in_alaw[8*k +: 8];
            end
        end
    end

    assign bus.in_ready = ready_vec;
    assign xfer         = |(bus.in_valid & ready_vec);

    // Arbitration FSM. A stall never ends a burst; a lost valid on the
    // locked channel or reaching BURST transfers hands the grant onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            lock      <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (xfer) begin
                        burst_cnt <= 4'd1;
                        if (BURST > 1) begin
                            state <= HOLD;
                            lock  <= grant;
                        end else begin
                            rr_ptr <= next_ch(grant);
                        end
                    end
                end
                HOLD: begin
                    if (!bus.in_valid[lock]) begin
                        state  <= ARB;
                        rr_ptr <= next_ch(lock);
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        if (burst_done) begin
                            state  <= ARB;
                            rr_ptr <= next_ch(lock);
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Output register: a new transfer always finds the slot free, so it
    // may overwrite; otherwise a consumed sample simply clears valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_lin   <= '0;
            bus.out_ch    <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_lin   <= expand(sel_code);
            bus.out_ch    <= sel_ch;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef ALAW_ARB_STATS_EN
    logic [CNT_W-1:0] acc_cnt [NUM_CH];

    // Saturating per-channel accept counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.in_valid[k] && ready_vec[k] && (acc_cnt[k] != '1)) begin
                    acc_cnt[k] <= acc_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_val = (int'(cnt_sel) < NUM_CH) ? acc_cnt[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_alaw_decode_arbiter.sv
// tb_alaw_decode_arbiter
//   Scoreboard bench for alaw_decode_arbiter. Two instances share clk/rst:
//   u_dut1 with BURST=1 and u_dut3 with BURST=3. Per-channel source FIFOs
//   present samples; expected {channel, linear} pairs are queued as
//   stimulus is issued and popped by a monitor on every output handshake.
module tb_alaw_decode_arbiter;

    localparam int NUM_CH = 4;
    localparam int CHW    = 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [14:0] exp1 [$];
    logic [14:0] exp3 [$];

    logic [7:0] mem1 [NUM_CH][32];
    logic [7:0] mem3 [NUM_CH][32];
    int wr1 [NUM_CH] = '{default: 0};
    int rd1 [NUM_CH] = '{default: 0};
    int wr3 [NUM_CH] = '{default: 0};
    int rd3 [NUM_CH] = '{default: 0};

    // Hand-expanded A-law vectors.
    logic [7:0]  code_tab [10] = '{8'h00, 8'h7F, 8'h85, 8'h25, 8'h13,
                                   8'h9A, 8'h47, 8'hF0, 8'h3C, 8'h61};
    logic [12:0] lin_tab  [10] = '{13'h0001, 13'h0FC0, 13'h100B, 13'h0056, 13'h0027,
                                   13'h1035, 13'h0178, 13'h1840, 13'h00E4, 13'h0460};

    alaw_decode_arbiter_if #(.NUM_CH(NUM_CH), .CHW(CHW)) bus1 ();
    alaw_decode_arbiter_if #(.NUM_CH(NUM_CH), .CHW(CHW)) bus3 ();

`ifdef ALAW_ARB_STATS_EN
    logic [CHW-1:0] cnt_sel1;
    logic [CHW-1:0] cnt_sel3;
    logic [15:0]    cnt_val1;
    logic [3:0]     cnt_val3;
`endif

    alaw_decode_arbiter #(
        .NUM_CH(NUM_CH), .CHW(CHW), .BURST(1)
`ifdef ALAW_ARB_STATS_EN
        , .CNT_W(16)
`endif
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
`ifdef ALAW_ARB_STATS_EN
        .cnt_sel(cnt_sel1),
        .cnt_val(cnt_val1),
`endif
        .bus(bus1)
    );

    alaw_decode_arbiter #(
        .NUM_CH(NUM_CH), .CHW(CHW), .BURST(3)
`ifdef ALAW_ARB_STATS_EN
        , .CNT_W(4)
`endif
    ) u_dut3 (
        .clk(clk),
        .rst(rst),
`ifdef ALAW_ARB_STATS_EN
        .cnt_sel(cnt_sel3),
        .cnt_val(cnt_val3),
`endif
        .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input int dut, input int ch, input int idx, input bit expect_out);
        if (dut == 1) begin
            mem1[ch][wr1[ch]] = code_tab[idx];
            wr1[ch]++;
            if (expect_out) exp1.push_back({CHW'(ch), lin_tab[idx]});
        end else begin
            mem3[ch][wr3[ch]] = code_tab[idx];
            wr3[ch]++;
            if (expect_out) exp3.push_back({CHW'(ch), lin_tab[idx]});
        end
    endtask

    task automatic expectOut3(input int ch, input int idx);
        exp3.push_back({CHW'(ch), lin_tab[idx]});
    endtask

    task automatic expectStream(input string name, input int dut, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput(name, (dut == 1) ? bus1.out_valid : bus3.out_valid, 1);
        end
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while ((exp1.size() != 0 || exp3.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp1.size() != 0 || exp3.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout pending=%0d required=0", exp1.size() + exp3.size());
        end
        @(negedge clk);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    // Source FIFOs present their head sample on the falling edge.
    initial begin
        bus1.in_valid = '0;
        bus1.in_alaw  = '0;
        bus3.in_valid = '0;
        bus3.in_alaw  = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                bus1.in_valid[c]       = (rd1[c] < wr1[c]);
                bus1.in_alaw[8*c +: 8] = (rd1[c] < wr1[c]) ? mem1[c][rd1[c]] : 8'hAA;
                bus3.in_valid[c]       = (rd3[c] < wr3[c]);
                bus3.in_alaw[8*c +: 8] = (rd3[c] < wr3[c]) ? mem3[c][rd3[c]] : 8'hAA;
            end
        end
    end

    // Sources retire a sample on each accepted input transfer.
    initial begin
        forever begin
            @(posedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus1.in_valid[c] && bus1.in_ready[c]) rd1[c]++;
                if (bus3.in_valid[c] && bus3.in_ready[c]) rd3[c]++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (exp1.size() == 0) begin
                checkOutput("dut1_unexpected_out", {bus1.out_ch, bus1.out_lin}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("dut1_out", {bus1.out_ch, bus1.out_lin}, exp1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus3.out_valid && bus3.out_ready) begin
            if (exp3.size() == 0) begin
                checkOutput("dut3_unexpected_out", {bus3.out_ch, bus3.out_lin}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("dut3_out", {bus3.out_ch, bus3.out_lin}, exp3.pop_front());
            end
        end
    end

    initial begin
        bus1.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
`ifdef ALAW_ARB_STATS_EN
        cnt_sel1 = '0;
        cnt_sel3 = '0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid1", bus1.out_valid, 0);
        checkOutput("rst_out_lin1", bus1.out_lin, 0);
        checkOutput("rst_out_ch1", bus1.out_ch, 0);
        checkOutput("rst_in_ready1", bus1.in_ready, 0);
        checkOutput("rst_out_valid3", bus3.out_valid, 0);
        rst = 1'b0;

        // Single ch0 sample, latency 1.
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1_latency_valid", bus1.out_valid, 1);
        checkOutput("t1_ch", bus1.out_ch, 0);
        checkOutput("t1_lin", bus1.out_lin, 13'h0001);
        waitDrain(20);

        // Three ch1 codes back to back.
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) applyStimulus(1, 1, k, 1);
        expectStream("t2_no_gap", 1, 3);
        waitDrain(20);

        // BURST=1 round-robin over all four channels from reset.
        pulseReset();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NUM_CH; c++) applyStimulus(1, c, (c * 3 + k) % 10, 1);
        end
        expectStream("t3_rate", 1, 12);
        waitDrain(30);

        // Output stall: held output stable, no input accepted.
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        applyStimulus(1, 2, 4, 1);
        applyStimulus(1, 3, 5, 1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_stall_valid", bus1.out_valid, 1);
            checkOutput("t5_stall_ch", bus1.out_ch, 2);
            checkOutput("t5_stall_lin", bus1.out_lin, 13'h0027);
            checkOutput("t5_stall_in_ready", bus1.in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        waitDrain(30);

        // BURST=3 with ch0 and ch2 always valid.
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NUM_CH; c += 2) begin
                for (int k = 0; k < 3; k++) applyStimulus(3, c, (b * 6 + (c / 2) * 3 + k) % 10, 1);
            end
        end
        expectStream("t4_burst_rate", 3, 12);
        waitDrain(40);

        // ch0 drops valid after one sample; grant moves to ch2.
        @(posedge clk); #1;
        applyStimulus(3, 0, 7, 1);
        applyStimulus(3, 2, 8, 1);
        applyStimulus(3, 2, 9, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4b_first_ch", bus3.out_ch, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4b_handover_valid", bus3.out_valid, 1);
        checkOutput("t4b_handover_ch", bus3.out_ch, 2);
        waitDrain(30);

        // Reset mid-HOLD while holding an unconsumed sample.
        @(posedge clk); #1;
        bus3.out_ready = 1'b0;
        applyStimulus(3, 1, 5, 0);
        applyStimulus(3, 1, 6, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_pre_valid", bus3.out_valid, 1);
        checkOutput("t6_pre_ch", bus3.out_ch, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_out_valid", bus3.out_valid, 0);
        checkOutput("t6_rst_out_lin", bus3.out_lin, 0);
        checkOutput("t6_rst_out_ch", bus3.out_ch, 0);
        checkOutput("t6_rst_in_ready", bus3.in_ready, 0);
`ifdef ALAW_ARB_STATS_EN
        checkOutput("t6_rst_cnt1_ch0", cnt_val1, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_sel3 = CHW'(c);
            #1;
            checkOutput("t6_rst_cnt3", cnt_val3, 0);
        end
`endif
        bus3.out_ready = 1'b1;
        applyStimulus(3, 0, 2, 1);
        expectOut3(1, 6);
        applyStimulus(3, 3, 4, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        waitDrain(30);

`ifdef ALAW_ARB_STATS_EN
        cnt_sel3 = CHW'(1);
        #1;
        checkOutput("stats_ch1_count", cnt_val3, 1);
        cnt_sel3 = CHW'(2);
        #1;
        checkOutput("stats_ch2_count", cnt_val3, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) applyStimulus(3, 0, i % 10, 1);
        waitDrain(80);
        cnt_sel3 = CHW'(0);
        #1;
        checkOutput("stats_saturate", cnt_val3, 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
